inst_fetch: RTL and testbench

- Instruction sequencer directly upstream of the 16-bit multicycle processor.
- Fetches instruction words from a synchronous program ROM and drives them onto the processor's DIN with a one-cycle Run pulse.
- Waits for the processor's Done, then advances the program counter.
- Provides run/single-step control, halt-opcode detection, an instruction counter and a stuck-processor watchdog.

---
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: reads words from a synchronous program ROM, issues
// each one to the multicycle processor with a one-cycle Run strobe, then waits for Done.
module inst_fetch #(
  parameter int unsigned   AW         = 8,
  parameter logic [AW-1:0] START_ADDR = '0,
  parameter int unsigned   TIMEOUT    = 15
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Go,
  input  logic          Step,
  output logic [AW-1:0] MemAddr,
  input  logic [15:0]   MemData,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [15:0]   InstCount
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    ISSUE    = 3'd3,
    EXEC     = 3'd4,
    HALT     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wdog;
  logic       halt_op;
  logic       wd_expired;
  logic       retire;
  logic       restart;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:13] == 3'b111;
  endfunction

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc_cur);
    return pc_cur + AW'(1);
  endfunction

  // The ROM is addressed straight from the PC so the word for PC is always the
  // one arriving on MemData one cycle later.
  assign MemAddr    = PC;
  assign halt_op    = is_halt(MemData);
  assign wd_expired = (wdog == WD_LAST);
  assign retire     = (state == EXEC) && Done;
  assign restart    = ((state == HALT) || (state == ERROR)) && Go;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Go) state_nxt = FETCH;
      FETCH:    state_nxt = WAIT_MEM;
      WAIT_MEM: state_nxt = halt_op ? HALT : ISSUE;
      ISSUE:    state_nxt = EXEC;
      EXEC: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (Done)            state_nxt = Step ? IDLE : FETCH;
        else if (wd_expired) state_nxt = ERROR;
      end
      HALT:     if (Go) state_nxt = FETCH;
      ERROR:    if (Go) state_nxt = FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      PC        <= START_ADDR;
      DIN       <= '0;
      Run       <= 1'b0;
      InstCount <= '0;
      wdog      <= '0;
      Busy      <= 1'b0;
      Halted    <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Status outputs are registered from the next state so they line up with it.
      Run    <= (state_nxt == ISSUE);
      Busy   <= (state_nxt == FETCH) || (state_nxt == WAIT_MEM) ||
                (state_nxt == ISSUE) || (state_nxt == EXEC);
      Halted <= (state_nxt == HALT);
      Error  <= (state_nxt == ERROR);

      if ((state == WAIT_MEM) && !halt_op) DIN <= MemData;

      if (retire) begin
        PC        <= pc_inc(PC);
        InstCount <= InstCount + 16'd1;
      end else if (restart) begin
        PC <= START_ADDR;
      end

      if ((state == ISSUE) || restart) wdog <= '0;
      else if (state == EXEC)          wdog <= wdog + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: ROM and multicycle-processor models, a Run scoreboard,
// and a second instance with START_ADDR = 8'hFE for PC wrap and reset.
`timescale 1ns/1ps
module tb_inst_fetch;

  localparam int AW = 8;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          Resetn, Go, Step, Done, Run, Busy, Halted, Error;
  logic [AW-1:0] MemAddr, PC;
  logic [15:0]   MemData, DIN, InstCount;

  logic          Resetn2, Go2, Done2, Run2, Busy2, Halted2, Error2;
  logic [AW-1:0] MemAddr2, PC2;
  logic [15:0]   MemData2, DIN2, InstCount2;

  int n_checks = 0;
  int n_pass   = 0;
  int run_count = 0;
  logic [15:0] exp_q[$];

  logic [15:0] rom  [0:255];
  logic [15:0] rom2 [0:255];

  logic done_force_en, done_force_val, model_done;

  inst_fetch #(.AW(AW), .START_ADDR(8'h00), .TIMEOUT(15)) dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .Step(Step),
    .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done),
    .PC(PC), .Busy(Busy), .Halted(Halted), .Error(Error), .InstCount(InstCount)
  );

  inst_fetch #(.AW(AW), .START_ADDR(8'hFE), .TIMEOUT(15)) u_wrap (
    .Clock(Clock), .Resetn(Resetn2), .Go(Go2), .Step(1'b0),
    .MemAddr(MemAddr2), .MemData(MemData2), .DIN(DIN2), .Run(Run2), .Done(Done2),
    .PC(PC2), .Busy(Busy2), .Halted(Halted2), .Error(Error2), .InstCount(InstCount2)
  );

  always @(posedge Clock) MemData  <= rom[MemAddr];
  always @(posedge Clock) MemData2 <= rom2[MemAddr2];

  // Processor model: mv (000/001) takes 1 step, everything else 3; Done in the last step.
  logic [15:0] preg [0:7];
  logic [15:0] p_ir, p_opnd;
  logic        p_busy;
  logic [1:0]  p_cnt;
  assign model_done = p_busy && (p_cnt == 2'd0);
  assign Done       = done_force_en ? done_force_val : model_done;
  assign p_opnd     = p_ir[12] ? {7'd0, p_ir[8:0]} : preg[p_ir[2:0]];

  always @(posedge Clock) begin
    if (!Resetn) begin
      p_busy <= 1'b0;
      p_cnt  <= 2'd0;
      p_ir   <= 16'd0;
      for (int r = 0; r < 8; r++) preg[r] <= 16'd0;
    end else if (Run) begin
      p_ir   <= DIN;
      p_busy <= 1'b1;
      p_cnt  <= (DIN[15:14] == 2'b00) ? 2'd0 : 2'd2;
    end else if (p_busy) begin
      if (p_cnt == 2'd0) begin
        p_busy <= 1'b0;
        case (p_ir[15:13])
          3'b000:  preg[p_ir[11:9]] <= p_opnd;
          3'b010:  preg[p_ir[11:9]] <= preg[p_ir[11:9]] + p_opnd;
          3'b011:  preg[p_ir[11:9]] <= preg[p_ir[11:9]] - p_opnd;
          default: ;
        endcase
      end else begin
        p_cnt <= p_cnt - 2'd1;
      end
    end
  end

  // Scoreboard: every Run pops the next expected instruction word.
  initial begin
    logic [15:0] e;
    logic run_prev;
    run_prev = 1'b0;
    forever begin
      @(negedge Clock);
      if (Run === 1'b1) begin
        run_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL run_unexpected: got Run with DIN=%h, expected no Run", DIN);
        end else begin
          e = exp_q.pop_front();
          if (DIN !== e) $display("FAIL run_din: got %h expected %h", DIN, e);
          else n_pass++;
        end
        n_checks++;
        if (run_prev === 1'b1) $display("FAIL run_width: got Run high 2 cycles, expected 1");
        else n_pass++;
      end
      run_prev = Run;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200us, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Go = 1'b1; Step = 1'b0;
    tick(2);
    n_checks++; if (PC !== 8'h00) $display("FAIL reset_pc: got %h expected 00", PC); else n_pass++;
    n_checks++; if (Run !== 1'b0) $display("FAIL reset_run: got %b expected 0", Run); else n_pass++;
    n_checks++; if (DIN !== 16'h0000) $display("FAIL reset_din: got %h expected 0000", DIN); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else n_pass++;
    n_checks++; if (InstCount !== 16'd0) $display("FAIL reset_count: got %0d expected 0", InstCount); else n_pass++;
    n_checks++; if ({Halted, Error} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {Halted, Error}); else n_pass++;
    Resetn = 1'b1;
    tick(1);
    n_checks++; if (Busy !== 1'b1) $display("FAIL reset_go_busy: got %b expected 1", Busy); else n_pass++;
    Resetn = 1'b0; Go = 1'b0;
    tick(1);
    n_checks++; if (Busy !== 1'b0 || PC !== 8'h00) $display("FAIL reset_reassert: got Busy=%b PC=%h expected 0/00", Busy, PC); else n_pass++;
    Resetn = 1'b1;
    tick(1);
  endtask

  task automatic test_single_mv();
    rom[0] = 16'h1005; rom[1] = 16'hE000;
    exp_q.push_back(16'h1005);
    Go = 1'b1; tick(1); Go = 1'b0;
    n_checks++; if (Run !== 1'b0) $display("FAIL mv_run_c1: got %b expected 0", Run); else n_pass++;
    tick(1);
    n_checks++; if (Run !== 1'b0) $display("FAIL mv_run_c2: got %b expected 0", Run); else n_pass++;
    tick(1);
    n_checks++; if (Run !== 1'b1 || DIN !== 16'h1005) $display("FAIL mv_issue: got Run=%b DIN=%h expected 1/1005", Run, DIN); else n_pass++;
    tick(2);
    n_checks++; if (PC !== 8'h01 || InstCount !== 16'd1) $display("FAIL mv_retire: got PC=%h cnt=%0d expected 01/1", PC, InstCount); else n_pass++;
    tick(2);
    n_checks++; if (Halted !== 1'b1 || Busy !== 1'b0) $display("FAIL mv_halt: got Halted=%b Busy=%b expected 1/0", Halted, Busy); else n_pass++;
    tick(5);
    n_checks++; if (PC !== 8'h01 || Halted !== 1'b1) $display("FAIL mv_halt_hold: got PC=%h Halted=%b expected 01/1", PC, Halted); else n_pass++;
    n_checks++; if (preg[0] !== 16'd5) $display("FAIL mv_r0: got %0d expected 5", preg[0]); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL mv_pending: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_mixed();
    int base;
    Resetn = 1'b0; tick(1); Resetn = 1'b1;
    rom[0] = 16'h1005; rom[1] = 16'h4000; rom[2] = 16'h7003; rom[3] = 16'hE000;
    base = run_count;
    exp_q.push_back(16'h1005); exp_q.push_back(16'h4000); exp_q.push_back(16'h7003);
    Go = 1'b1; tick(1); Go = 1'b0;
    for (int i = 0; i < 60 && Halted !== 1'b1; i++) tick(1);
    n_checks++; if (Halted !== 1'b1) $display("FAIL mix_halt1: got Halted=%b expected 1", Halted); else n_pass++;
    n_checks++; if (InstCount !== 16'd3 || PC !== 8'h03) $display("FAIL mix_count1: got cnt=%0d PC=%h expected 3/03", InstCount, PC); else n_pass++;
    n_checks++; if (run_count - base != 3) $display("FAIL mix_runs1: got %0d expected 3", run_count - base); else n_pass++;
    n_checks++; if (preg[0] !== 16'd7) $display("FAIL mix_r0: got %0d expected 7", preg[0]); else n_pass++;
    exp_q.push_back(16'h1005); exp_q.push_back(16'h4000); exp_q.push_back(16'h7003);
    Go = 1'b1; tick(1); Go = 1'b0;
    n_checks++; if (PC !== 8'h00 || Busy !== 1'b1) $display("FAIL mix_restart: got PC=%h Busy=%b expected 00/1", PC, Busy); else n_pass++;
    for (int i = 0; i < 60 && Halted !== 1'b1; i++) tick(1);
    n_checks++; if (Halted !== 1'b1 || InstCount !== 16'd6) $display("FAIL mix_halt2: got Halted=%b cnt=%0d expected 1/6", Halted, InstCount); else n_pass++;
    n_checks++; if (run_count - base != 6) $display("FAIL mix_runs2: got %0d expected 6", run_count - base); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL mix_pending: got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_step();
    int base;
    Resetn = 1'b0; tick(1); Resetn = 1'b1;
    Step = 1'b1;
    rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h1003;
    for (int i = 0; i < 3; i++) begin
      base = run_count;
      exp_q.push_back(rom[i]);
      Go = 1'b1; tick(1); Go = 1'b0;
      if (i == 0) begin
        tick(1); Go = 1'b1; tick(1); Go = 1'b0;
      end
      for (int k = 0; k < 20 && Busy !== 1'b0; k++) tick(1);
      n_checks++; if (Busy !== 1'b0 || Halted !== 1'b0 || Error !== 1'b0) $display("FAIL step_idle%0d: got Busy=%b Halted=%b Error=%b expected 000", i, Busy, Halted, Error); else n_pass++;
      n_checks++; if (PC !== 8'(i + 1)) $display("FAIL step_pc%0d: got %h expected %h", i, PC, 8'(i + 1)); else n_pass++;
      tick(3);
      n_checks++; if (run_count - base != 1 || Busy !== 1'b0) $display("FAIL step_runs%0d: got runs=%0d Busy=%b expected 1/0", i, run_count - base, Busy); else n_pass++;
    end
    Step = 1'b0;
  endtask

  task automatic test_watchdog();
    Resetn = 1'b0; tick(1); Resetn = 1'b1;
    rom[0] = 16'h1005; rom[1] = 16'hE000;
    done_force_en = 1'b1; done_force_val = 1'b0;
    exp_q.push_back(16'h1005);
    Go = 1'b1; tick(1); Go = 1'b0;
    for (int k = 0; k < 10 && Run !== 1'b1; k++) tick(1);
    n_checks++; if (Run !== 1'b1) $display("FAIL wd_issue1: got Run=%b expected 1", Run); else n_pass++;
    tick(15);
    n_checks++; if (Error !== 1'b0 || Busy !== 1'b1) $display("FAIL wd_early: got Error=%b Busy=%b expected 0/1", Error, Busy); else n_pass++;
    tick(1);
    n_checks++; if (Error !== 1'b1 || Busy !== 1'b0) $display("FAIL wd_expire: got Error=%b Busy=%b expected 1/0", Error, Busy); else n_pass++;
    n_checks++; if (PC !== 8'h00 || InstCount !== 16'd0) $display("FAIL wd_hold: got PC=%h cnt=%0d expected 00/0", PC, InstCount); else n_pass++;
    exp_q.push_back(16'h1005);
    Go = 1'b1; tick(1); Go = 1'b0;
    n_checks++; if (Error !== 1'b0 || Busy !== 1'b1 || PC !== 8'h00) $display("FAIL wd_restart: got Error=%b Busy=%b PC=%h expected 0/1/00", Error, Busy, PC); else n_pass++;
    for (int k = 0; k < 10 && Run !== 1'b1; k++) tick(1);
    n_checks++; if (Run !== 1'b1) $display("FAIL wd_issue2: got Run=%b expected 1", Run); else n_pass++;
    tick(15);
    done_force_val = 1'b1;
    tick(1);
    done_force_val = 1'b0;
    n_checks++; if (Error !== 1'b0 || PC !== 8'h01 || InstCount !== 16'd1) $display("FAIL wd_done_wins: got Error=%b PC=%h cnt=%0d expected 0/01/1", Error, PC, InstCount); else n_pass++;
    done_force_en = 1'b0;
    for (int k = 0; k < 10 && Halted !== 1'b1; k++) tick(1);
    n_checks++; if (Halted !== 1'b1 || exp_q.size() != 0) $display("FAIL wd_end: got Halted=%b pending=%0d expected 1/0", Halted, exp_q.size()); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    logic [7:0] ea;
    rom2[8'hFE] = 16'h1011; rom2[8'hFF] = 16'h1022; rom2[8'h00] = 16'h1033; rom2[8'h01] = 16'h1044;
    Resetn2 = 1'b1; tick(1);
    n_checks++; if (PC2 !== 8'hFE || MemAddr2 !== 8'hFE) $display("FAIL wrap_start: got PC=%h MemAddr=%h expected FE/FE", PC2, MemAddr2); else n_pass++;
    Go2 = 1'b1; tick(1); Go2 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      ea = 8'hFE + 8'(j);
      for (int k = 0; k < 10 && Run2 !== 1'b1; k++) tick(1);
      n_checks++; if (Run2 !== 1'b1 || PC2 !== ea || DIN2 !== rom2[ea]) $display("FAIL wrap_issue%0d: got Run=%b PC=%h DIN=%h expected 1/%h/%h", j, Run2, PC2, DIN2, ea, rom2[ea]); else n_pass++;
      tick(1);
      Done2 = 1'b1; tick(1); Done2 = 1'b0;
      n_checks++; if (PC2 !== ea + 8'd1 || InstCount2 !== 16'(j + 1)) $display("FAIL wrap_pc%0d: got PC=%h cnt=%0d expected %h/%0d", j, PC2, InstCount2, ea + 8'd1, j + 1); else n_pass++;
    end
    for (int k = 0; k < 10 && Run2 !== 1'b1; k++) tick(1);
    tick(1);
    n_checks++; if (Busy2 !== 1'b1 || Run2 !== 1'b0 || Halted2 !== 1'b0 || Error2 !== 1'b0) $display("FAIL wrap_exec: got Busy=%b Run=%b Halted=%b Error=%b expected 1000", Busy2, Run2, Halted2, Error2); else n_pass++;
    Resetn2 = 1'b0; tick(1);
    n_checks++; if (Run2 !== 1'b0 || Busy2 !== 1'b0 || PC2 !== 8'hFE) $display("FAIL wrap_reset: got Run=%b Busy=%b PC=%h expected 0/0/FE", Run2, Busy2, PC2); else n_pass++;
    n_checks++; if (InstCount2 !== 16'd0 || DIN2 !== 16'h0000) $display("FAIL wrap_reset_data: got cnt=%0d DIN=%h expected 0/0000", InstCount2, DIN2); else n_pass++;
    Resetn2 = 1'b1; tick(1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      rom[a]  = 16'h1000;
      rom2[a] = 16'h1000;
    end
    Resetn = 1'b0; Go = 1'b0; Step = 1'b0;
    done_force_en = 1'b0; done_force_val = 1'b0;
    Resetn2 = 1'b0; Go2 = 1'b0; Done2 = 1'b0;
    test_reset();
    test_single_mv();
    test_mixed();
    test_step();
    test_watchdog();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
